// File: rtl/m_mem_access_if.sv
// rtl/m_mem_access_if.sv - req/ack data-memory bus between the M stage and DM/timers/IG.
interface m_mem_access_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, we, addr, byteen, wdata, input ack, rdata);
   modport slave  (input req, we, addr, byteen, wdata, output ack, rdata);
endinterface

// File: rtl/m_mem_access.sv
// rtl/m_mem_access.sv - M-stage memory access: address check, bus transaction, load extend.
module m_mem_access #(
   parameter logic [31:0] DM_TOP   = 32'h0000_2FFF,
   parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
   parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
   parameter logic [31:0] IG_BASE  = 32'h0000_7F20
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            M_mem_op,
   input  logic [31:0]           M_ALUAns,
   input  logic [31:0]           M_rt_data,
   input  logic [4:0]            M_EXCCode,
   input  logic                  M_EXC_DMOv,
   input  logic                  Req,
   m_mem_access_if.master        bus,
   output logic                  M_stall,
   output logic [31:0]           M_ld_data,
   output logic [4:0]            M_EXCCode_o
);
   localparam logic [3:0] OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4,
                          OP_LBU = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB = 4'd8;
   localparam logic [31:0] TC_SIZE = 32'd12;
   localparam logic [31:0] IG_SIZE = 32'd4;
   localparam logic [4:0]  EXC_ADEL = 5'd4;
   localparam logic [4:0]  EXC_ADES = 5'd5;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t      state;
   logic        drain;
   logic [3:0]  lat_op;
   logic [1:0]  lat_lo;

   logic        is_load, is_store, valid_op, is_word, is_half;
   logic        in_dm, in_tc0, in_tc1, in_timer, in_ig, misalign, bad_addr, start_ok;
   logic [31:0] tc_off;
   logic [3:0]  byteen_c;
   logic [31:0] wdata_c;

   always_comb begin
      is_load  = (M_mem_op >= OP_LW) && (M_mem_op <= OP_LBU);
      is_store = (M_mem_op >= OP_SW) && (M_mem_op <= OP_SB);
      valid_op = is_load || is_store;
      is_word  = (M_mem_op == OP_LW) || (M_mem_op == OP_SW);
      is_half  = (M_mem_op == OP_LH) || (M_mem_op == OP_LHU) || (M_mem_op == OP_SH);

      in_dm    = M_ALUAns <= DM_TOP;
      in_tc0   = (M_ALUAns >= TC0_BASE) && (M_ALUAns < TC0_BASE + TC_SIZE);
      in_tc1   = (M_ALUAns >= TC1_BASE) && (M_ALUAns < TC1_BASE + TC_SIZE);
      in_timer = in_tc0 || in_tc1;
      in_ig    = (M_ALUAns >= IG_BASE) && (M_ALUAns < IG_BASE + IG_SIZE);
      tc_off   = in_tc0 ? (M_ALUAns - TC0_BASE) : (M_ALUAns - TC1_BASE);

      misalign = (is_word && (M_ALUAns[1:0] != 2'b00)) || (is_half && M_ALUAns[0]);
      // Timers accept whole-word accesses only, and COUNT is read-only.
      bad_addr = misalign || M_EXC_DMOv || !(in_dm || in_timer || in_ig)
                 || (in_timer && !is_word)
                 || (in_timer && is_store && (tc_off == 32'd8));

      if (M_EXCCode != 5'd0)
         M_EXCCode_o = M_EXCCode;
      else if (valid_op && bad_addr)
         M_EXCCode_o = is_load ? EXC_ADEL : EXC_ADES;
      else
         M_EXCCode_o = 5'd0;

      start_ok = valid_op && (M_EXCCode_o == 5'd0) && !Req;

      if (is_word)
         byteen_c = 4'b1111;
      else if (is_half)
         byteen_c = 4'b0011 << {M_ALUAns[1], 1'b0};
      else
         byteen_c = 4'b0001 << M_ALUAns[1:0];

      case (M_mem_op)
         OP_SH:   wdata_c = {2{M_rt_data[15:0]}};
         OP_SB:   wdata_c = {4{M_rt_data[7:0]}};
         default: wdata_c = M_rt_data;
      endcase

      case (state)
         IDLE:    M_stall = start_ok;
         // A draining transaction only holds back a memory op waiting behind it.
         BUSY:    M_stall = !Req && (!drain || valid_op);
         default: M_stall = 1'b0;
      endcase
   end

   function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] lo,
                                            input logic [31:0] w);
      logic [31:0] s;
      s = w >> {lo, 3'b000};
      case (op)
         OP_LH:   load_ext = {{16{s[15]}}, s[15:0]};
         OP_LHU:  load_ext = {16'h0000, s[15:0]};
         OP_LB:   load_ext = {{24{s[7]}}, s[7:0]};
         OP_LBU:  load_ext = {24'h000000, s[7:0]};
         default: load_ext = w;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         drain      <= 1'b0;
         lat_op     <= 4'd0;
         lat_lo     <= 2'd0;
         bus.req    <= 1'b0;
         bus.we     <= 1'b0;
         bus.addr   <= 32'd0;
         bus.byteen <= 4'd0;
         bus.wdata  <= 32'd0;
         M_ld_data  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  lat_op     <= M_mem_op;
                  lat_lo     <= M_ALUAns[1:0];
                  bus.req    <= 1'b1;
                  bus.we     <= is_store;
                  bus.addr   <= {M_ALUAns[31:2], 2'b00};
                  bus.byteen <= byteen_c;
                  bus.wdata  <= wdata_c;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (bus.ack) begin
                  bus.req <= 1'b0;
                  if (drain || Req) begin
                     drain <= 1'b0;
                     state <= IDLE;
                  end else begin
                     if (!bus.we)
                        M_ld_data <= load_ext(lat_op, lat_lo, bus.rdata);
                     state <= DONE;
                  end
               end else if (Req) begin
                  drain <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_m_mem_access.sv
// tb/tb_m_mem_access.sv - directed scoreboard bench for m_mem_access.
module tb_m_mem_access;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  M_mem_op = 4'd0;
   logic [31:0] M_ALUAns = 32'd0;
   logic [31:0] M_rt_data = 32'd0;
   logic [4:0]  M_EXCCode = 5'd0;
   logic        M_EXC_DMOv = 1'b0;
   logic        Req = 1'b0;
   logic        M_stall;
   logic [31:0] M_ld_data;
   logic [4:0]  M_EXCCode_o;

   m_mem_access_if bus();

   m_mem_access dut (
      .clk(clk), .reset(reset), .M_mem_op(M_mem_op), .M_ALUAns(M_ALUAns),
      .M_rt_data(M_rt_data), .M_EXCCode(M_EXCCode), .M_EXC_DMOv(M_EXC_DMOv),
      .Req(Req), .bus(bus), .M_stall(M_stall), .M_ld_data(M_ld_data),
      .M_EXCCode_o(M_EXCCode_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] ld;
   } exp_t;

   exp_t sbq[$];
   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(output bit got);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.req === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      chk("req_seen", {31'd0, got}, 32'd1);
   endtask

   task automatic access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt,
                         input int dly, input logic [31:0] rd, input exp_t e);
      exp_t x;
      bit   got;
      sbq.push_back(e);
      @(negedge clk);
      M_mem_op = op; M_ALUAns = a; M_rt_data = rt;
      #1 chk("stall_start", {31'd0, M_stall}, 32'd1);
      wait_req(got);
      x = sbq.pop_front();
      if (!got) begin
         M_mem_op = 4'd0;
         return;
      end
      chk("bus_addr", bus.addr, x.addr);
      chk("bus_we", {31'd0, bus.we}, {31'd0, x.we});
      if (x.we) begin
         chk("bus_byteen", {28'd0, bus.byteen}, {28'd0, x.be});
         chk("bus_wdata", bus.wdata, x.wd);
      end
      for (int i = 0; i < dly; i++) begin
         #1 chk("stall_wait", {31'd0, M_stall}, 32'd1);
         @(negedge clk);
         chk("req_hold", {31'd0, bus.req}, 32'd1);
      end
      bus.ack = 1'b1; bus.rdata = rd;
      #1 chk("stall_ack", {31'd0, M_stall}, 32'd1);
      @(negedge clk);
      bus.ack = 1'b0; bus.rdata = 32'd0;
      #1 chk("stall_done", {31'd0, M_stall}, 32'd0);
      chk("req_done", {31'd0, bus.req}, 32'd0);
      if (!x.we) chk("ld_data", M_ld_data, x.ld);
      M_mem_op = 4'd0;
   endtask

   task automatic exc(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic dmov, input logic [4:0] inexc, input logic [4:0] want);
      @(negedge clk);
      M_mem_op = op; M_ALUAns = a; M_EXC_DMOv = dmov; M_EXCCode = inexc;
      #1 chk(tag, {27'd0, M_EXCCode_o}, {27'd0, want});
      chk("exc_nostall", {31'd0, M_stall}, 32'd0);
      @(posedge clk);
      #1 chk("exc_noreq", {31'd0, bus.req}, 32'd0);
      M_mem_op = 4'd0; M_EXC_DMOv = 1'b0; M_EXCCode = 5'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      exp_t e;
      bit   got;
      bus.ack = 1'b0;
      bus.rdata = 32'd0;

      repeat (2) @(negedge clk);
      chk("rst_req", {31'd0, bus.req}, 32'd0);
      chk("rst_addr", bus.addr, 32'd0);
      chk("rst_byteen", {28'd0, bus.byteen}, 32'd0);
      chk("rst_wdata", bus.wdata, 32'd0);
      chk("rst_ld", M_ld_data, 32'd0);
      chk("rst_stall", {31'd0, M_stall}, 32'd0);
      reset = 1'b1;

      // Loads: word and sign/zero extended sub-word lanes.
      e = '{1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF};
      access(4'd1, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, e);
      e = '{1'b0, 32'h10, 4'h8, 32'h0, 32'hFFFF_FF80};
      access(4'd4, 32'h13, 32'h0, 0, 32'h80FF_0000, e);
      e = '{1'b0, 32'h10, 4'h8, 32'h0, 32'h0000_0080};
      access(4'd5, 32'h13, 32'h0, 1, 32'h80FF_0000, e);
      e = '{1'b0, 32'h10, 4'hC, 32'h0, 32'hFFFF_80FF};
      access(4'd2, 32'h12, 32'h0, 0, 32'h80FF_0000, e);
      e = '{1'b0, 32'h10, 4'hC, 32'h0, 32'h0000_80FF};
      access(4'd3, 32'h12, 32'h0, 2, 32'h80FF_0000, e);
      e = '{1'b0, 32'h2FFC, 4'hF, 32'h0, 32'h0BAD_F00D};
      access(4'd1, 32'h2FFC, 32'h0, 0, 32'h0BAD_F00D, e);

      // Stores: lane-shifted data and byte enables.
      e = '{1'b1, 32'h4, 4'hC, 32'hABCD_ABCD, 32'h0};
      access(4'd7, 32'h6, 32'h1234_ABCD, 0, 32'h0, e);
      e = '{1'b1, 32'h7F20, 4'h2, 32'h5555_5555, 32'h0};
      access(4'd8, 32'h7F21, 32'h0000_0055, 1, 32'h0, e);
      e = '{1'b1, 32'h7F04, 4'hF, 32'hCAFE_0001, 32'h0};
      access(4'd6, 32'h7F04, 32'hCAFE_0001, 2, 32'h0, e);
      @(negedge clk);
      chk("store_keeps_ld", M_ld_data, 32'h0BAD_F00D);

      // Address exceptions and pass-through.
      exc("sw_count",   4'd6, 32'h7F08, 1'b0, 5'd0,  5'd5);
      exc("lw_outside", 4'd1, 32'h3000, 1'b0, 5'd0,  5'd4);
      exc("lh_timer",   4'd2, 32'h7F00, 1'b0, 5'd0,  5'd4);
      exc("sw_dmov",    4'd6, 32'h20,   1'b1, 5'd0,  5'd5);
      exc("lw_misal",   4'd1, 32'h2,    1'b0, 5'd0,  5'd4);
      exc("sb_tc1",     4'd8, 32'h7F13, 1'b0, 5'd0,  5'd5);
      exc("passthru",   4'd1, 32'h20,   1'b0, 5'd10, 5'd10);
      exc("op_none",    4'd9, 32'h9999, 1'b0, 5'd0,  5'd0);

      // Flush in the 2nd BUSY cycle; handler lw waits for the drain ack.
      @(negedge clk);
      M_mem_op = 4'd1; M_ALUAns = 32'h20;
      wait_req(got);
      @(negedge clk);
      Req = 1'b1;
      #1 chk("flush_stall", {31'd0, M_stall}, 32'd0);
      chk("flush_req", {31'd0, bus.req}, 32'd1);
      @(negedge clk);
      Req = 1'b0;
      e = '{1'b0, 32'h24, 4'hF, 32'h0, 32'h1122_3344};
      sbq.push_back(e);
      M_mem_op = 4'd1; M_ALUAns = 32'h24;
      #1 chk("drain_stall1", {31'd0, M_stall}, 32'd1);
      chk("drain_req1", {31'd0, bus.req}, 32'd1);
      @(negedge clk);
      chk("drain_req2", {31'd0, bus.req}, 32'd1);
      @(negedge clk);
      bus.ack = 1'b1; bus.rdata = 32'hFFFF_FFFF;
      #1 chk("drain_stall_ack", {31'd0, M_stall}, 32'd1);
      @(negedge clk);
      bus.ack = 1'b0;
      #1 chk("drain_idle_req", {31'd0, bus.req}, 32'd0);
      chk("drain_discard", M_ld_data, 32'h0BAD_F00D);
      chk("handler_stall", {31'd0, M_stall}, 32'd1);
      wait_req(got);
      e = sbq.pop_front();
      chk("handler_addr", bus.addr, e.addr);
      bus.ack = 1'b1; bus.rdata = 32'h1122_3344;
      @(negedge clk);
      bus.ack = 1'b0;
      #1 chk("handler_ld", M_ld_data, e.ld);
      chk("handler_nostall", {31'd0, M_stall}, 32'd0);
      M_mem_op = 4'd0;

      // Asynchronous reset abandons an in-flight transaction.
      @(negedge clk);
      M_mem_op = 4'd1; M_ALUAns = 32'h40;
      wait_req(got);
      #2 reset = 1'b0;
      #1 chk("arst_req", {31'd0, bus.req}, 32'd0);
      chk("arst_ld", M_ld_data, 32'd0);
      M_mem_op = 4'd0;
      @(negedge clk);
      reset = 1'b1;
      e = '{1'b0, 32'h40, 4'hF, 32'h0, 32'h7654_3210};
      access(4'd1, 32'h40, 32'h0, 1, 32'h7654_3210, e);

      @(negedge clk);
      chk("sbq_empty", sbq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
